// File: rtl/div_pkg.sv
// Shared constants and helpers for the sequential restoring divider.
// State encoding, counter sizing and two's-complement magnitude handling live here.
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Widest operand the magnitude helpers can carry; callers size-cast in and out.
  localparam int MAX_W = 64;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

  function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] v);
    return ~v + 64'd1;
  endfunction

  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v,
                                                 input logic neg);
    return neg ? twos_neg(v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference only when it does not go negative.
module div_step
  import div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W:0]   rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dvs_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);

  logic [W+1:0] trial;

  // The extra top bit of trial acts as the borrow that signals a restore.
  always_comb begin
    trial = {rem_i, bit_i} - {2'b00, dvs_i};
    q_o   = ~trial[W+1];
    rem_o = q_o ? trial[W:0] : {rem_i[W-1:0], bit_i};
  end

endmodule

// File: rtl/div_seq.sv
// Parametrised sequential restoring divider with unsigned/signed modes,
// busy/done handshake, remainder output and divide-by-zero flag.
module div_seq
  import div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         sgn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         dz
);

  localparam int CNT_W = cnt_width(W);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W:0]       rem_q, rem_d;
  logic [W-1:0]     dvd_q, dvd_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [W-1:0]     q_q, q_d;
  logic [W-1:0]     r_q, r_d;
  logic             dz_q, dz_d;

  logic [W:0]       rem_next;
  logic             q_bit;

  div_step #(.W(W)) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[W-1]),
    .dvs_i (dvs_q),
    .rem_o (rem_next),
    .q_o   (q_bit)
  );

  // dvd_q doubles as the quotient register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;

    case (state_q)
      ST_IDLE: begin
        if (ld) begin
          dz_d    = 1'b0;
          neg_q_d = sgn & (a[W-1] ^ b[W-1]);
          neg_r_d = sgn & a[W-1];
          if (b == '0) begin
            q_d     = '1;
            r_d     = a;
            dz_d    = 1'b1;
            state_d = ST_FIN;
          end else begin
            dvd_d   = W'(cond_neg(MAX_W'(a), sgn & a[W-1]));
            dvs_d   = W'(cond_neg(MAX_W'(b), sgn & b[W-1]));
            rem_d   = '0;
            cnt_d   = CNT_W'(W - 1);
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        rem_d = rem_next;
        dvd_d = {dvd_q[W-2:0], q_bit};
        if (cnt_q == '0) begin
          // Sign fix-up happens on the same edge that publishes the result.
          q_d     = W'(cond_neg(MAX_W'({dvd_q[W-2:0], q_bit}), neg_q_q));
          r_d     = W'(cond_neg(MAX_W'(rem_next[W-1:0]), neg_r_q));
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_FIN);
  assign q    = q_q;
  assign r    = r_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: a W=4 and a W=8 instance share one clock;
// expected results come from plain integer division on sign-extended operands.
module tb_div_seq;

  typedef struct {
    longint q;
    longint r;
    bit     dz;
    longint cyc;
  } exp_t;

  logic       clk;
  logic       rst;

  logic       ld4, sgn4, busy4, done4, dz4;
  logic [3:0] a4, b4, q4, r4;
  logic       ld8, sgn8, busy8, done8, dz8;
  logic [7:0] a8, b8, q8, r8;

  exp_t   sb4[$];
  exp_t   sb8[$];
  longint cyc;
  int     checkCount;
  int     passCount;

  div_seq #(.W(4)) u_div4 (
    .clk(clk), .rst(rst), .ld(ld4), .sgn(sgn4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .q(q4), .r(r4), .dz(dz4)
  );

  div_seq #(.W(8)) u_div8 (
    .clk(clk), .rst(rst), .ld(ld8), .sgn(sgn8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .q(q8), .r(r8), .dz(dz8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Compare one observed value against the bench's own expectation.
  task automatic checkOutput(input string name, input longint act, input longint exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  // Reference: integer division truncating toward zero; remainder follows dividend.
  function automatic void refModel(input int w, input bit s, input longint a,
                                   input longint b, output longint eq,
                                   output longint er, output bit edz);
    longint full, mask, sa, sb;
    full = longint'(1) << w;
    mask = full - 1;
    if (b == 0) begin
      eq = mask;
      er = a;
      edz = 1'b1;
      return;
    end
    edz = 1'b0;
    if (!s) begin
      eq = a / b;
      er = a % b;
    end else begin
      sa = (a >= full / 2) ? a - full : a;
      sb = (b >= full / 2) ? b - full : b;
      eq = sa / sb;
      er = sa % sb;
    end
    eq = eq & mask;
    er = er & mask;
  endfunction

  // Monitors: pop an expectation whenever the DUT raises done.
  always @(negedge clk) begin
    exp_t e;
    if (rst && done4) begin
      if (sb4.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL w4_unexpected_done actual done=1 required done=0");
      end else begin
        e = sb4.pop_front();
        checkOutput("w4_q", longint'(q4), e.q);
        checkOutput("w4_r", longint'(r4), e.r);
        checkOutput("w4_dz", longint'(dz4), longint'(e.dz));
        checkOutput("w4_latency", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && done8) begin
      if (sb8.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL w8_unexpected_done actual done=1 required done=0");
      end else begin
        e = sb8.pop_front();
        checkOutput("w8_q", longint'(q8), e.q);
        checkOutput("w8_r", longint'(r8), e.r);
        checkOutput("w8_dz", longint'(dz8), longint'(e.dz));
        checkOutput("w8_latency", cyc, e.cyc);
      end
    end
  end

  // Issue one load to the chosen instance and queue its expected response.
  task automatic applyStimulus(input bit w4, input bit s, input longint a, input longint b);
    exp_t   e;
    longint c;
    int     w;
    w = w4 ? 4 : 8;
    refModel(w, s, a, b, e.q, e.r, e.dz);
    @(negedge clk);
    if (w4) begin
      ld4 = 1'b1; sgn4 = s; a4 = 4'(a); b4 = 4'(b);
    end else begin
      ld8 = 1'b1; sgn8 = s; a8 = 8'(a); b8 = 8'(b);
    end
    c = cyc;
    e.cyc = c + 1 + ((b == 0) ? 0 : w);
    if (w4) sb4.push_back(e);
    else    sb8.push_back(e);
    @(posedge clk);
    #1;
    if (w4) begin
      ld4 = 1'b0;
      checkOutput("w4_busy_after_load", longint'(busy4), 1);
    end else begin
      ld8 = 1'b0;
      checkOutput("w8_busy_after_load", longint'(busy8), 1);
    end
  endtask

  // Wait (bounded) until the scoreboard drains, then check the cycle after done.
  task automatic waitDone(input bit w4);
    int n;
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      n = w4 ? sb4.size() : sb8.size();
      if (n == 0) break;
    end
    if (n != 0) begin
      checkCount++;
      $display("[TB] FAIL %s_done_timeout actual pending=%0d required pending=0",
               w4 ? "w4" : "w8", n);
      if (w4) sb4.delete();
      else    sb8.delete();
    end
    @(negedge clk);
    if (w4) begin
      checkOutput("w4_busy_after_done", longint'(busy4), 0);
      checkOutput("w4_done_after_done", longint'(done4), 0);
    end else begin
      checkOutput("w8_busy_after_done", longint'(busy8), 0);
      checkOutput("w8_done_after_done", longint'(done8), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit     s;
    longint a, b;
    int     sel;
    checkCount = 0;
    passCount  = 0;
    rst = 1'b0;
    ld4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
    ld8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    #1;
    checkOutput("rst_busy8", longint'(busy8), 0);
    checkOutput("rst_done8", longint'(done8), 0);
    checkOutput("rst_q8", longint'(q8), 0);
    checkOutput("rst_r8", longint'(r8), 0);
    checkOutput("rst_dz8", longint'(dz8), 0);
    checkOutput("rst_busy4", longint'(busy4), 0);
    #11 rst = 1'b1;

    // W=4 directed: plain divide, divide by zero, dz cleared by next divide.
    applyStimulus(1, 0, 11, 2);  waitDone(1);
    applyStimulus(1, 0, 9, 0);   waitDone(1);
    applyStimulus(1, 0, 11, 2);  waitDone(1);
    applyStimulus(1, 1, 4'h8, 4'hF); waitDone(1);
    for (int i = 0; i < 12; i++) begin
      s = 1'($urandom_range(0, 1));
      a = longint'($urandom_range(0, 15));
      b = longint'($urandom_range(0, 15));
      applyStimulus(1, s, a, b);
      waitDone(1);
    end

    // W=8 signed directed cases, including the wrap case.
    applyStimulus(0, 1, 8'hF9, 2);    waitDone(0);
    applyStimulus(0, 1, 7, 8'hFE);    waitDone(0);
    applyStimulus(0, 1, 8'h80, 8'hFF); waitDone(0);
    applyStimulus(0, 1, 8'h85, 0);    waitDone(0);

    // A load during RUN must be ignored.
    applyStimulus(0, 0, 200, 7);
    repeat (3) @(negedge clk);
    ld8 = 1'b1; sgn8 = 1'b0; a8 = 8'd1; b8 = 8'd1;
    repeat (2) @(negedge clk);
    ld8 = 1'b0;
    waitDone(0);
    applyStimulus(0, 0, 1, 1);        waitDone(0);

    // Asynchronous reset in the middle of RUN.
    applyStimulus(0, 0, 100, 7);      waitDone(0);
    applyStimulus(0, 0, 250, 3);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("midrun_rst_busy", longint'(busy8), 0);
    checkOutput("midrun_rst_done", longint'(done8), 0);
    checkOutput("midrun_rst_q", longint'(q8), 0);
    checkOutput("midrun_rst_r", longint'(r8), 0);
    checkOutput("midrun_rst_dz", longint'(dz8), 0);
    sb8.delete();
    #2 rst = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("post_rst_idle_busy", longint'(busy8), 0);
    applyStimulus(0, 0, 100, 10);     waitDone(0);

    // W=8 randomized mix with extra weight on boundary divisors and dividends.
    for (int i = 0; i < 40; i++) begin
      s   = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      a   = (sel == 3) ? 128 : longint'($urandom_range(0, 255));
      case (sel)
        0:       b = 0;
        1:       b = 255;
        2:       b = 1;
        default: b = longint'($urandom_range(0, 255));
      endcase
      applyStimulus(0, s, a, b);
      waitDone(0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
